// File: rtl/ps2_keyboard_rx_pkg.sv
`default_nettype none
// ============================================================================
//  ps2_keyboard_rx_pkg
//  Shared scan-code constants, frame FSM states and helpers for the PS/2 RX.
//  Revision: 1.0 - initial release
// ============================================================================
package ps2_keyboard_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_KBD_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_KBD_ERR_HI = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       brk;
  } key_event_t;

  // Odd parity over data+parity, and a high stop bit.
  function automatic logic frame_good(input logic [7:0] data_byte,
                                      input logic       parity_bit,
                                      input logic       stop_bit);
    return stop_bit && (^{data_byte, parity_bit});
  endfunction

  function automatic logic is_key_byte(input logic [7:0] data_byte);
    return (data_byte != PS2_PREFIX_EXT) && (data_byte != PS2_PREFIX_BRK) &&
           (data_byte != PS2_KBD_ERR_LO) && (data_byte != PS2_KBD_ERR_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  ps2_frame_rx
//  Pin synchroniser, PS/2 clock glitch filter, 11-bit frame FSM and timeout.
//  Revision: 1.0 - initial release
// ============================================================================
module ps2_frame_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_error
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic           clk_meta, clk_sync, data_meta, data_sync;
  logic [FCW-1:0] filt_cnt;
  logic           clk_filt, clk_filt_d;
  logic [TCW-1:0] to_cnt;
  frame_state_t   state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           parity_bit;

  logic fall, timeout, stop_fall, good;

  always_ff @(posedge clk) begin
    if (clr) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk;
      clk_sync   <= clk_meta;
      data_meta  <= ps2_data;
      data_sync  <= data_meta;
      clk_filt_d <= clk_filt;
      // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall      = clk_filt_d & ~clk_filt;
  assign timeout   = (state != ST_IDLE) && !fall && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign stop_fall = fall && (state == ST_STOP);
  assign good      = frame_good(shift, parity_bit, data_sync);

  always_ff @(posedge clk) begin
    if (clr || fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TCW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
    end else if (timeout) begin
      state <= ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state   <= ST_DATA;
            bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          shift   <= {data_sync, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          parity_bit <= data_sync;
          state      <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_byte     = shift;
  assign byte_strobe = stop_fall && good;
  assign frame_error = (stop_fall && !good) || timeout;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  ps2_keyboard_rx
//  PS/2 keyboard receiver: folds E0/F0 prefixes into key events on valid/ready.
//  Revision: 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       frame_error,
  output logic       overrun
);

  logic [7:0] rx_byte;
  logic       byte_strobe;
  logic       rx_error;
  logic       ext_pend, brk_pend;
  logic       new_event;
  key_event_t held;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_error(rx_error)
  );

  assign new_event = byte_strobe && is_key_byte(rx_byte);

  always_ff @(posedge clk) begin
    if (clr) begin
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      frame_error <= 1'b0;
      key_valid   <= 1'b0;
      overrun     <= 1'b0;
      held        <= '0;
    end else begin
      frame_error <= rx_error;

      if (rx_error) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_strobe) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end

      // A pending unaccepted event wins; the newcomer is dropped and flagged.
      if (new_event) begin
        if (!key_valid || key_ready) begin
          held      <= '{code: rx_byte, extended: ext_pend, brk: brk_pend};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign key_code     = held.code;
  assign key_extended = held.extended;
  assign key_release  = held.brk;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  tb_ps2_keyboard_rx
//  Directed PS/2 frame stimulus with hand-computed expected key events.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int HALF    = 40;   // clk cycles per PS/2 clock half-period
  localparam int GAP     = 60;
  localparam int TIMEOUT = 16000;
  localparam int PIPE    = 7;    // pin drive to FSM action: 2 sync + 4 filter + 1

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [9:0] ev_q[$];

  ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_release (key_release),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!clr) begin
      if (key_valid && key_ready) ev_q.push_back({key_code, key_extended, key_release});
      if (frame_error) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    if (nbits == 11) repeat (GAP) @(negedge clk);
  endtask

  task automatic expect_one(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    check_eq({tag, "_count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) check_eq({tag, "_event"}, ev_q[0], {code, ext, rel});
    ev_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int cnt;
    logic seen;

    repeat (5) @(negedge clk);
    check_eq("rst_valid", key_valid, 0);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_ext_rel", {key_extended, key_release}, 0);
    check_eq("rst_err_ovr", {frame_error, overrun}, 0);
    clr = 1'b0;
    repeat (20) @(negedge clk);

    // 1: single make code with latency check on the stop bit
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 10);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (PIPE - 1) @(negedge clk);
    check_eq("t1_valid_early", key_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_lat", key_valid, 1);
    check_eq("t1_code_lat", key_code, 8'h1C);
    repeat (HALF - PIPE) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
    expect_one("t1", 8'h1C, 1'b0, 1'b0);
    check_eq("t1_err", err_cnt - e0, 0);

    // 2: extended break
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    expect_one("t2", 8'h75, 1'b1, 1'b1);

    // 3: parity error, then error clears a pending break
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 11);
    check_eq("t3_err1", err_cnt - e0, 1);
    check_eq("t3_no_event", ev_q.size(), 0);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 11);
    check_eq("t3_err3", err_cnt - e0, 2);
    expect_one("t3", 8'h1C, 1'b0, 1'b0);

    // 4: overrun while consumer stalls
    @(posedge clk); #1 key_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h32, 1'b0, 11);
    check_eq("t4_valid_held", key_valid, 1);
    check_eq("t4_code_held", key_code, 8'h1C);
    check_eq("t4_overrun", overrun, 1);
    check_eq("t4_no_accept", ev_q.size(), 0);
    @(posedge clk); #1 key_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t4_valid_drop", key_valid, 0);
    expect_one("t4", 8'h1C, 1'b0, 1'b0);

    // 5: timeout after a partial frame
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 4);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < TIMEOUT + 1000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == HALF) ps2_clk = 1'b1;
      if (frame_error) seen = 1'b1;
    end
    ps2_clk = 1'b1;
    check_eq("t5_timeout_seen", seen, 1);
    cnt = cnt - PIPE;
    check_eq("t5_timeout_lat", (cnt >= TIMEOUT - 3 && cnt <= TIMEOUT + 3) ? TIMEOUT : cnt, TIMEOUT);
    @(negedge clk);
    check_eq("t5_pulse_width", frame_error, 0);
    repeat (GAP) @(negedge clk);
    send_frame(8'h29, 1'b0, 11);
    check_eq("t5_err", err_cnt - e0, 1);
    expect_one("t5", 8'h29, 1'b0, 1'b0);

    // 6: short glitches on ps2_clk are ignored
    e0 = err_cnt;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_eq("t6_glitch_err", err_cnt - e0, 0);
    check_eq("t6_glitch_event", ev_q.size(), 0);
    send_frame(8'h1C, 1'b0, 11);
    expect_one("t6_after_glitch", 8'h1C, 1'b0, 1'b0);

    // clear in the middle of a frame
    @(posedge clk); #1 key_ready = 1'b0;
    send_frame(8'h32, 1'b0, 11);
    send_frame(8'h29, 1'b0, 4);
    check_eq("t6_pre_clr", {key_valid, overrun}, 2'b11);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_eq("t6_clr_valid", key_valid, 0);
    check_eq("t6_clr_code", key_code, 0);
    check_eq("t6_clr_flags", {key_extended, key_release, frame_error, overrun}, 0);
    clr = 1'b0;
    key_ready = 1'b1;
    ev_q.delete();
    e0 = err_cnt;
    repeat (TIMEOUT + 200) @(negedge clk);
    check_eq("t6_no_err_after_clr", err_cnt - e0, 0);
    check_eq("t6_no_event_after_clr", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
